// File: rtl/skolem_sweep_checker.sv
// -----------------------------------------------------------------------------
// skolem_sweep_checker
//   Exhaustively sweeps all 256 (s,t) operand pairs into an attached Skolem
//   function block and classifies each returned x:
//     pass   : (x + s) mod 16 >s t   (4-bit two's complement compare)
//     fail   : comparison false, t != 7
//     vacuous: t == 7, where no x can satisfy the relation
//   Each vector is held for SETTLE cycles, then sampled for one cycle.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset (release synchronised)
//   start      in   one-cycle sweep request, honoured only in IDLE
//   s_out      out  operand s  -> Skolem i0..i3
//   t_out      out  bound t    -> Skolem i4..i7
//   x_in       in   result x   <- Skolem i8..i11
//   busy       out  sweep in progress (DRIVE/SAMPLE)
//   done       out  one-cycle pulse at sweep end
//   pass_cnt   out  passing vector count
//   fail_cnt   out  failing vector count
//   vac_cnt    out  vacuous vector count (t = 7)
//   first_fail out  {x,t,s} of the first failing vector
//   fail_seen  out  first_fail holds a valid capture
// -----------------------------------------------------------------------------
module skolem_sweep_checker #(
    parameter int unsigned SETTLE       = 1,
    parameter bit          STOP_ON_FAIL = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [3:0]  s_out,
    output logic [3:0]  t_out,
    input  logic [3:0]  x_in,
    output logic        busy,
    output logic        done,
    output logic [8:0]  pass_cnt,
    output logic [8:0]  fail_cnt,
    output logic [8:0]  vac_cnt,
    output logic [11:0] first_fail,
    output logic        fail_seen
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_rst_sync;
    logic [7:0]  r_vec;
    logic [3:0]  r_settle;
    logic [8:0]  r_pass;
    logic [8:0]  r_fail;
    logic [8:0]  r_vac;
    logic [11:0] r_first;
    logic        r_seen;

    logic        w_start_ok;
    logic [3:0]  w_sum;
    logic        w_vac;
    logic        w_pass;
    logic        w_fail;
    logic        w_settled;
    logic        w_last;

    // Reset asserts asynchronously everywhere, but start is only honoured once
    // the release has crossed two flops, so the first accepted start lands at
    // least two edges after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= '0;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_start_ok = start && r_rst_sync[1];
    assign w_sum      = x_in + r_vec[3:0];
    assign w_vac      = (r_vec[7:4] == 4'b0111);
    assign w_pass     = $signed(w_sum) > $signed(r_vec[7:4]);
    assign w_fail     = !w_vac && !w_pass;
    assign w_settled  = (r_settle == SETTLE_LAST);
    assign w_last     = (r_vec == 8'hFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_ok) begin
                    w_next = DRIVE;
                end
            end
            DRIVE: begin
                busy = 1'b1;
                if (w_settled) begin
                    w_next = SAMPLE;
                end
            end
            SAMPLE: begin
                busy = 1'b1;
                if (w_last || (STOP_ON_FAIL && w_fail)) begin
                    w_next = DONE;
                end else begin
                    w_next = DRIVE;
                end
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec    <= '0;
            r_settle <= '0;
            r_pass   <= '0;
            r_fail   <= '0;
            r_vac    <= '0;
            r_first  <= '0;
            r_seen   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        r_vec    <= '0;
                        r_settle <= '0;
                        r_pass   <= '0;
                        r_fail   <= '0;
                        r_vac    <= '0;
                        r_first  <= '0;
                        r_seen   <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (!w_settled) begin
                        r_settle <= r_settle + 4'd1;
                    end
                end
                SAMPLE: begin
                    r_settle <= '0;
                    if (w_vac) begin
                        r_vac <= r_vac + 9'd1;
                    end else if (w_pass) begin
                        r_pass <= r_pass + 9'd1;
                    end else begin
                        r_fail <= r_fail + 9'd1;
                        if (!r_seen) begin
                            r_first <= {x_in, r_vec[7:4], r_vec[3:0]};
                            r_seen  <= 1'b1;
                        end
                    end
                    // vec stays at the final vector when the sweep ends
                    if (w_next == DRIVE) begin
                        r_vec <= r_vec + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s_out      = r_vec[3:0];
    assign t_out      = r_vec[7:4];
    assign pass_cnt   = r_pass;
    assign fail_cnt   = r_fail;
    assign vac_cnt    = r_vac;
    assign first_fail = r_first;
    assign fail_seen  = r_seen;

endmodule

// File: tb/tb_skolem_sweep_checker.sv
module tb_skolem_sweep_checker;

    localparam int NI = 3;
    // instance 0: SETTLE=1, instance 1: SETTLE=3, instance 2: SETTLE=1 stop-on-fail
    localparam int unsigned SETTLE_P [NI] = '{1, 3, 1};
    localparam bit          STOP_P   [NI] = '{1'b0, 1'b0, 1'b1};

    typedef struct {
        int     inst;
        int     pass_n;
        int     fail_n;
        int     vac_n;
        int     seen;
        int     ff;
        int     lat;
        longint done_cycle;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start      [NI];
    logic [3:0]  s_out      [NI];
    logic [3:0]  t_out      [NI];
    logic [3:0]  x_in       [NI];
    logic        busy       [NI];
    logic        done       [NI];
    logic [8:0]  pass_cnt   [NI];
    logic [8:0]  fail_cnt   [NI];
    logic [8:0]  vac_cnt    [NI];
    logic [11:0] first_fail [NI];
    logic        fail_seen  [NI];
    logic [3:0]  lut        [NI][256];

    longint cyc;
    int     n_checks;
    int     n_fail;
    exp_t   q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_dut
        skolem_sweep_checker #(
            .SETTLE      (SETTLE_P[g]),
            .STOP_ON_FAIL(STOP_P[g])
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start[g]),
            .s_out     (s_out[g]),
            .t_out     (t_out[g]),
            .x_in      (x_in[g]),
            .busy      (busy[g]),
            .done      (done[g]),
            .pass_cnt  (pass_cnt[g]),
            .fail_cnt  (fail_cnt[g]),
            .vac_cnt   (vac_cnt[g]),
            .first_fail(first_fail[g]),
            .fail_seen (fail_seen[g])
        );

        // Skolem block stand-in: a table indexed by {t,s}
        assign x_in[g] = lut[g][{t_out[g], s_out[g]}];

        exp_t e_m;
        always @(negedge clk) begin
            if (done[g] === 1'b1) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done inst%0d: got done=1, required done=0", g);
                end else begin
                    e_m = q.pop_front();
                    chk($sformatf("done_inst%0d", g), g, e_m.inst);
                    chk($sformatf("pass_cnt inst%0d", g), longint'(pass_cnt[g]), e_m.pass_n);
                    chk($sformatf("fail_cnt inst%0d", g), longint'(fail_cnt[g]), e_m.fail_n);
                    chk($sformatf("vac_cnt inst%0d", g), longint'(vac_cnt[g]), e_m.vac_n);
                    chk($sformatf("fail_seen inst%0d", g), longint'(fail_seen[g]), e_m.seen);
                    chk($sformatf("first_fail inst%0d", g), longint'(first_fail[g]), e_m.ff);
                    chk($sformatf("done_cycle inst%0d", g), cyc, e_m.done_cycle);
                    chk($sformatf("busy_at_done inst%0d", g), longint'(busy[g]), 0);
                end
            end
        end
    end

    // Reference: walk every (s,t) in sweep order, apply the signed rule with
    // integer arithmetic, stop early where the instance stops on failure.
    function automatic exp_t model(input int g);
        exp_t e;
        int n, s, t, x, sum, ss, tt;
        e.inst = g; e.pass_n = 0; e.fail_n = 0; e.vac_n = 0;
        e.seen = 0; e.ff = 0; e.lat = 0; e.done_cycle = 0;
        n = 0;
        for (int v = 0; v < 256; v++) begin
            s = v % 16;
            t = v / 16;
            x = int'(lut[g][v]);
            n++;
            if (t == 7) begin
                e.vac_n++;
            end else begin
                sum = (x + s) % 16;
                ss  = (sum >= 8) ? sum - 16 : sum;
                tt  = (t >= 8) ? t - 16 : t;
                if (ss > tt) begin
                    e.pass_n++;
                end else begin
                    e.fail_n++;
                    if (e.seen == 0) begin
                        e.seen = 1;
                        e.ff   = x * 256 + t * 16 + s;
                    end
                    if (STOP_P[g]) break;
                end
            end
        end
        e.lat = n * (int'(SETTLE_P[g]) + 1) + 1;
        return e;
    endfunction

    // mode 0: correct Skolem answer, 1: x tied to 0, 2: random x
    task automatic fill(input int g, input int mode);
        int s, t;
        for (int v = 0; v < 256; v++) begin
            s = v % 16;
            t = v / 16;
            case (mode)
                0:       lut[g][v] = (t == 7) ? 4'($urandom_range(0, 15)) : 4'((t + 1 - s + 16) % 16);
                1:       lut[g][v] = 4'd0;
                default: lut[g][v] = 4'($urandom_range(0, 15));
            endcase
        end
    endtask

    task automatic wait_drain(input int budget);
        for (int k = 0; k < budget && q.size() != 0; k++) @(posedge clk);
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sweep_timeout: got %0d pending results, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic run_sweep(input int g, input int mode);
        exp_t e;
        fill(g, mode);
        e = model(g);
        @(posedge clk); #1;
        e.done_cycle = cyc + e.lat;
        q.push_back(e);
        start[g] = 1'b1;
        @(posedge clk); #1;
        start[g] = 1'b0;
        wait_drain(3000);
    endtask

    task automatic chk_reset(input int g, input string tag);
        chk($sformatf("%s busy%0d", tag, g), longint'(busy[g]), 0);
        chk($sformatf("%s done%0d", tag, g), longint'(done[g]), 0);
        chk($sformatf("%s s_out%0d", tag, g), longint'(s_out[g]), 0);
        chk($sformatf("%s t_out%0d", tag, g), longint'(t_out[g]), 0);
        chk($sformatf("%s pass_cnt%0d", tag, g), longint'(pass_cnt[g]), 0);
        chk($sformatf("%s fail_cnt%0d", tag, g), longint'(fail_cnt[g]), 0);
        chk($sformatf("%s vac_cnt%0d", tag, g), longint'(vac_cnt[g]), 0);
        chk($sformatf("%s first_fail%0d", tag, g), longint'(first_fail[g]), 0);
        chk($sformatf("%s fail_seen%0d", tag, g), longint'(fail_seen[g]), 0);
    endtask

    initial begin
        exp_t e;
        longint c0;
        int k;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        for (int g = 0; g < NI; g++) begin
            start[g] = 1'b0;
            for (int v = 0; v < 256; v++) lut[g][v] = 4'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < NI; g++) chk_reset(g, "por");
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // full sweeps, SETTLE=1
        run_sweep(0, 0);
        run_sweep(0, 1);
        run_sweep(0, 2);
        run_sweep(0, 2);
        // SETTLE=3
        run_sweep(1, 0);
        run_sweep(1, 2);
        // stop on first failure
        run_sweep(2, 1);
        run_sweep(2, 2);
        run_sweep(2, 0);

        // start held high: second sweep begins only after DONE returns to IDLE
        fill(0, 0);
        e = model(0);
        @(posedge clk); #1;
        c0 = cyc;
        e.done_cycle = c0 + e.lat;
        q.push_back(e);
        e.done_cycle = c0 + e.lat + 1 + e.lat;
        q.push_back(e);
        start[0] = 1'b1;
        repeat (600) @(posedge clk);
        #1;
        start[0] = 1'b0;
        wait_drain(3000);

        // reset mid-sweep at vec=100
        fill(0, 0);
        @(posedge clk); #1;
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        k = 0;
        while ({t_out[0], s_out[0]} != 8'd100 && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        chk("reach_vec100", longint'({t_out[0], s_out[0]}), 100);
        #2 rst_n = 1'b0;
        #1 chk_reset(0, "midrst");
        repeat (2) @(posedge clk);
        #1 chk_reset(0, "midrst_hold");
        @(posedge clk); #1;
        rst_n    = 1'b1;
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        chk("start_at_release_ignored", longint'(busy[0]), 0);
        repeat (3) @(posedge clk);
        #1 chk("idle_after_release", longint'(busy[0]), 0);
        run_sweep(0, 0);
        run_sweep(2, 1);

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/skolem_sweep_checker.md
SKOLEM_SWEEP_CHECKER -- requirements
Module: skolem_sweep_checker

Interface
REQ-001 SHALL have parameter SETTLE, default 1, meaning cycles a vector is held before x_in is sampled (legal range 1..15).
REQ-002 SHALL have parameter STOP_ON_FAIL, default 0, meaning 1 ends the sweep at the first failing vector.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: one-cycle request to begin a sweep.
REQ-006 SHALL have port s_out, output, 4 bits: operand s, driven to Skolem inputs i0..i3 (LSB first).
REQ-007 SHALL have port t_out, output, 4 bits: bound t, driven to Skolem inputs i4..i7 (LSB first).
REQ-008 SHALL have port x_in, input, 4 bits: Skolem result x, taken from outputs i8..i11 (LSB first).
REQ-009 SHALL have port busy, output, 1 bit: sweep in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse at sweep end.
REQ-011 SHALL have port pass_cnt, output, 9 bits: count of vectors that satisfy the check.
REQ-012 SHALL have port fail_cnt, output, 9 bits: count of vectors that violate the check.
REQ-013 SHALL have port vac_cnt, output, 9 bits: count of vectors with t = 4'b0111, where no x exists.
REQ-014 SHALL have port first_fail, output, 12 bits: {x,t,s} of the first failing vector.
REQ-015 SHALL have port fail_seen, output, 1 bit: first_fail is valid.

Function
REQ-016 SHALL implement FSM IDLE -> DRIVE -> SAMPLE -> (DRIVE | DONE) -> IDLE.
REQ-017 In IDLE, start=1 SHALL clear all counters, first_fail and fail_seen, set vec=0, and enter DRIVE; busy SHALL be 0 in IDLE and 1 in DRIVE and SAMPLE.
REQ-018 vec SHALL be an 8-bit counter with s_out = vec[3:0] and t_out = vec[7:4]; s_out and t_out SHALL be registered and stable throughout DRIVE and SAMPLE.
REQ-019 DRIVE SHALL last exactly SETTLE cycles, counted by an internal settle counter; SAMPLE SHALL last 1 cycle, during which x_in is evaluated.
REQ-020 Check: sum = (x_in + s_out) mod 16; pass iff sum >s t_out, with both operands read as 4-bit two's complement.
REQ-021 If t_out = 4'b0111, SAMPLE SHALL increment vac_cnt only, regardless of x_in.
REQ-022 Otherwise SAMPLE SHALL increment pass_cnt on pass or fail_cnt on fail.
REQ-023 On the first fail (fail_seen=0), the block SHALL latch first_fail = {x_in,t_out,s_out} and set fail_seen=1; later fails SHALL NOT alter first_fail.
REQ-024 After SAMPLE: if vec = 255, or a fail occurred with STOP_ON_FAIL=1, go to DONE; else increment vec and go to DRIVE.
REQ-025 DONE SHALL last 1 cycle with done=1 and busy=0, then go to IDLE.
REQ-026 Counters and first_fail SHALL hold their values in IDLE until the next accepted start.
REQ-027 start asserted while busy=1 or done=1 SHALL be ignored.
REQ-028 Counters SHALL NOT wrap; pass_cnt+fail_cnt+vac_cnt SHALL equal the number of vectors sampled, maximum 256.
REQ-029 Full-sweep latency SHALL be start accepted -> done high after 256*(SETTLE+1)+1 cycles, i.e. 513 cycles at SETTLE=1.
REQ-030 Every vector whose sum >s t comparison is computed SHALL be counted, including wrap-around cases such as s=7, x=1, sum=-8.

Reset
REQ-031 rst_n=0 SHALL asynchronously force state=IDLE, vec=0, s_out=0, t_out=0, busy=0, done=0, all counters=0, first_fail=0, fail_seen=0.
REQ-032 Reset asserted mid-sweep SHALL abort the sweep with no done pulse; after release the block SHALL wait in IDLE for start.
REQ-033 Reset release SHALL be synchronised to clk; the first accepted start SHALL be no earlier than the second clk edge after release.

Verification
REQ-034 Correct Skolem block attached, SETTLE=1, start pulse -> done after 513 cycles; pass_cnt=240, fail_cnt=0, vac_cnt=16, fail_seen=0.
REQ-035 x_in tied to 0 -> fail_cnt = number of (s,t) with t != 7 and s <=s t; first_fail = {0,0,0} (s=0, t=0).
REQ-036 x_in tied to 0, STOP_ON_FAIL=1 -> done after 3 cycles; fail_cnt=1, pass_cnt=0.
REQ-037 rst_n pulsed low at vec=100 -> outputs at reset values, no done; a new start gives a full, clean sweep.
REQ-038 start held high for 600 cycles -> exactly one sweep completes per accepted start; starts arriving during busy do not restart the sweep.
REQ-039 SETTLE=3, correct Skolem block -> done after 1025 cycles; same counts as REQ-034.
